// File: rtl/microcode_pipeline.sv
// Writable microcode control store and pipeline register that sit after an am2910 sequencer.
// The store is written through a valid/ready port; while it is written, the pipeline presents a JZ word.
module microcode_pipeline #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    y_addr,
    input  logic                 pl_n,
    input  logic                 map_n,
    input  logic                 vect_n,
    input  logic [ADDR_W-1:0]    map_addr,
    input  logic [ADDR_W-1:0]    vect_addr,
    input  logic [3:0]           cond_in,
    input  logic                 stall,
    input  logic                 prog_valid,
    output logic                 prog_ready,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [WORD_W-1:0]    prog_data,
    output logic [3:0]           seq_i,
    output logic [ADDR_W-1:0]    seq_d,
    output logic                 seq_ccen,
    output logic                 seq_rld,
    output logic                 seq_cc,
    output logic [WORD_W-13:0]   ctrl_out,
    output logic                 busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    // SAFE word: JZ, BA=0, CCEN=1, RLD=1, CC_SEL=0, user=0
    localparam logic [WORD_W-1:0] SAFE = WORD_W'(12'h300);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PROG  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   pr_q, pr_d;
    logic                prog_ready_q, prog_ready_d;
    logic                busy_q, busy_d;
    logic [WORD_W-1:0]   store_q [DEPTH];
    logic [WORD_W-1:0]   store_d [DEPTH];
    logic                wr_en;

    always_comb begin
        state_d = state_q;
        pr_d    = SAFE;
        case (state_q)
            RUN: begin
                if (prog_valid) begin
                    state_d = PROG;
                end else if (stall) begin
                    pr_d = pr_q;
                end else begin
                    pr_d = store_q[y_addr];
                end
            end
            PROG: begin
                if (!prog_valid) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        prog_ready_d = (state_d == PROG);
        busy_d       = (state_d != RUN);
    end

    // Writes only happen in PROG, so reads never need a bypass path
    assign wr_en = (state_q == PROG) && prog_valid && prog_ready_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            store_d[i] = store_q[i];
        end
        if (wr_en) begin
            store_d[prog_addr] = prog_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            pr_q         <= SAFE;
            prog_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pr_q         <= pr_d;
            prog_ready_q <= prog_ready_d;
            busy_q       <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= store_d[i];
            end
        end
    end

    always_comb begin
        if (!pl_n) begin
            seq_d = pr_q[4 +: ADDR_W];
        end else if (!map_n) begin
            seq_d = map_addr;
        end else if (!vect_n) begin
            seq_d = vect_addr;
        end else begin
            seq_d = '0;
        end
    end

    assign seq_cc     = cond_in[pr_q[11:10]];
    assign seq_i      = pr_q[3:0];
    assign seq_ccen   = pr_q[8];
    assign seq_rld    = pr_q[9];
    assign ctrl_out   = pr_q[WORD_W-1:12];
    assign prog_ready = prog_ready_q;
    assign busy       = busy_q;

endmodule
